// File: rtl/i8253_host.sv
// rtl/i8253_host.sv - bus-master sequencer issuing i8253 program and counter-readback cycles
module i8253_host #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_sel,
    input  logic [2:0]  req_mode,
    input  logic        req_bcd,
    input  logic [15:0] req_count,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_data,
    output logic        pit_cs,
    output logic        pit_rd,
    output logic        pit_wr,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_dout,
    input  logic [7:0]  pit_din
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t      state;
    logic [1:0]  step;
    logic [3:0]  strobe_cnt;
    logic        cur_write;
    logic [1:0]  cur_sel;
    logic [2:0]  cur_mode;
    logic        cur_bcd;
    logic [15:0] cur_count;
    logic [7:0]  lsb;
    logic [7:0]  msb;

    // Byte driven for access `step`: control/latch word first, then the count bytes (0 when reading).
    function automatic logic [7:0] access_byte(input logic wr, input logic [1:0] sel,
                                               input logic [2:0] mode, input logic bcd,
                                               input logic [15:0] count, input logic [1:0] stp);
        case (stp)
            2'd0:    return wr ? {sel, 2'b11, mode, bcd} : {sel, 6'b000000};
            2'd1:    return wr ? count[7:0] : 8'h00;
            default: return wr ? count[15:8] : 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] access_addr(input logic [1:0] sel, input logic [1:0] stp);
        return (stp == 2'd0) ? 2'd3 : sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 2'd0;
            strobe_cnt <= 4'd0;
            cur_write  <= 1'b0;
            cur_sel    <= 2'd0;
            cur_mode   <= 3'd0;
            cur_bcd    <= 1'b0;
            cur_count  <= 16'd0;
            lsb        <= 8'd0;
            msb        <= 8'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= 16'd0;
            pit_cs     <= 1'b0;
            pit_rd     <= 1'b0;
            pit_wr     <= 1'b0;
            pit_a      <= 2'd0;
            pit_dout   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    step <= 2'd0;
                    if (req_valid) begin
                        cur_write <= req_write;
                        cur_sel   <= req_sel;
                        cur_mode  <= req_mode;
                        cur_bcd   <= req_bcd;
                        cur_count <= req_count;
                        req_ready <= 1'b0;
                        if (req_sel == 2'd3) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 16'd0;
                        end else begin
                            state    <= SETUP;
                            pit_cs   <= 1'b1;
                            pit_a    <= access_addr(req_sel, 2'd0);
                            pit_dout <= access_byte(req_write, req_sel, req_mode, req_bcd,
                                                    req_count, 2'd0);
                        end
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    strobe_cnt <= STROBE_LOAD;
                    // The latch command is always a write; only the data accesses of a readback read.
                    pit_wr     <= cur_write || (step == 2'd0);
                    pit_rd     <= !cur_write && (step != 2'd0);
                end
                STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        state  <= HOLD;
                        pit_wr <= 1'b0;
                        pit_rd <= 1'b0;
                        if (pit_rd && step == 2'd1) lsb <= pit_din;
                        if (pit_rd && step == 2'd2) msb <= pit_din;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (step == 2'd2) begin
                        state      <= DONE;
                        pit_cs     <= 1'b0;
                        pit_a      <= 2'd0;
                        pit_dout   <= 8'd0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= cur_write ? 16'd0 : {msb, lsb};
                    end else begin
                        state    <= SETUP;
                        step     <= step + 2'd1;
                        pit_a    <= access_addr(cur_sel, step + 2'd1);
                        pit_dout <= access_byte(cur_write, cur_sel, cur_mode, cur_bcd,
                                                cur_count, step + 2'd1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    step       <= 2'd0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
